mem_bridge: RTL

- Sits directly downstream of the processor core. Merges its separate instruction-fetch and data-access handshakes onto one single-port memory bus with variable-latency acknowledge.
- Serialises requests, holds each memory transaction until acknowledged, and returns registered read data with a one-cycle valid pulse to the requesting side.
- Every returned word is a registered copy, so the core never sees memory-side combinational paths.

---
 rtl/mem_bridge_pkg.sv | 23 ++
 rtl/mem_bridge_if.sv | 50 +++++
 rtl/mem_bridge_watchdog.sv | 35 +++
 rtl/mem_bridge.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg
// Shared definitions for the memory bridge: FSM state encoding and the
// substitute words returned when a transaction is abandoned.
// No ports (package).
package mem_bridge_pkg;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_INSTR_WAIT = 2'd1;
  localparam logic [1:0] ST_DATA_WAIT  = 2'd2;
  localparam logic [1:0] ST_RECOVER    = 2'd3;

  typedef enum logic [1:0] {
    IDLE       = ST_IDLE,
    INSTR_WAIT = ST_INSTR_WAIT,
    DATA_WAIT  = ST_DATA_WAIT,
    RECOVER    = ST_RECOVER
  } state_t;

  // RISC-V canonical NOP (addi x0, x0, 0), handed to the core on a failed fetch
  localparam logic [31:0] NOP_INSTR         = 32'h00000013;
  localparam logic [31:0] DATA_TIMEOUT_WORD = 32'h00000000;

endpackage

// File: rtl/mem_bridge_if.sv
// mem_bridge_if
// Bundles the core-side fetch/data handshakes and the single-port memory bus.
// Parameters: ADR_W, DATA_W.
// Modports:
//   slave  - the bridge's view (core requests and memory responses in,
//            read data/valid and memory request out)
//   master - the environment's view (core plus memory), opposite directions
interface mem_bridge_if #(
  parameter int ADR_W  = 32,
  parameter int DATA_W = 32
);

  logic              INSTR_REQ;
  logic [ADR_W-1:0]  INSTR_ADR;
  logic [DATA_W-1:0] INSTR_READ;
  logic              INSTR_VALID;

  logic              DATA_REQ;
  logic              DATA_WRITE_ENABLE;
  logic [ADR_W-1:0]  DATA_ADR;
  logic [DATA_W-1:0] DATA_WRITE;
  logic [DATA_W-1:0] DATA_READ;
  logic              DATA_VALID;

  logic              MEM_REQ;
  logic              MEM_WE;
  logic [ADR_W-1:0]  MEM_ADR;
  logic [DATA_W-1:0] MEM_WDATA;
  logic [DATA_W-1:0] MEM_RDATA;
  logic              MEM_ACK;

  modport slave (
    input  INSTR_REQ, INSTR_ADR,
    output INSTR_READ, INSTR_VALID,
    input  DATA_REQ, DATA_WRITE_ENABLE, DATA_ADR, DATA_WRITE,
    output DATA_READ, DATA_VALID,
    output MEM_REQ, MEM_WE, MEM_ADR, MEM_WDATA,
    input  MEM_RDATA, MEM_ACK
  );

  modport master (
    output INSTR_REQ, INSTR_ADR,
    input  INSTR_READ, INSTR_VALID,
    output DATA_REQ, DATA_WRITE_ENABLE, DATA_ADR, DATA_WRITE,
    input  DATA_READ, DATA_VALID,
    input  MEM_REQ, MEM_WE, MEM_ADR, MEM_WDATA,
    output MEM_RDATA, MEM_ACK
  );

endinterface

// File: rtl/mem_bridge_watchdog.sv
// mem_bridge_watchdog
// Counts memory wait cycles and flags the cycle in which the LIMIT-th
// unacknowledged wait cycle is being spent.
// Ports:
//   clk     in  clock
//   rst     in  synchronous active-high reset
//   clear   in  force the count back to zero
//   enable  in  count this cycle
//   expired out count has reached LIMIT-1, i.e. this is the last allowed cycle
module mem_bridge_watchdog #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count_q;

  // Saturates once expired so the count can never wrap while held.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (enable && !expired) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired = (count_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_bridge.sv
// mem_bridge
// Merges the core's instruction-fetch and data-access handshakes onto one
// single-port memory bus. One transaction at a time; data requests win over
// fetches in IDLE. Read data is returned from registers together with a
// one-cycle VALID pulse, followed by one RECOVER cycle so the core can drop
// its request.
// Optional feature: MEM_BRIDGE_TIMEOUT_EN adds a wait-cycle watchdog that
// abandons a transaction after TIMEOUT cycles and sets a sticky ERR.
// Ports:
//   CLK   in  clock
//   RES   in  synchronous active-high reset
//   bus   mem_bridge_if.slave - core handshakes and memory bus
//   BUSY  out high whenever the FSM is not in IDLE
//   ERR   out sticky timeout flag (constant 0 without the watchdog)
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int ADR_W   = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RES,
  mem_bridge_if.slave bus,
  output logic        BUSY,
  output logic        ERR
);

  state_t            state_q, next_state;
  logic [ADR_W-1:0]  adr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic [DATA_W-1:0] instr_read_q;
  logic [DATA_W-1:0] data_read_q;
  logic              instr_valid_q;
  logic              data_valid_q;

  logic in_wait;
  logic accept_data;
  logic accept_instr;
  logic complete;
  logic timeout_hit;

  assign in_wait = (state_q == INSTR_WAIT) || (state_q == DATA_WAIT);

`ifdef MEM_BRIDGE_TIMEOUT_EN
  logic expired;
  logic err_q;

  // Cleared whenever we are outside a WAIT state, so the first WAIT cycle
  // always starts from zero.
  mem_bridge_watchdog #(
    .LIMIT(TIMEOUT)
  ) u_watchdog (
    .clk    (CLK),
    .rst    (RES),
    .clear  (!in_wait),
    .enable (in_wait && !bus.MEM_ACK),
    .expired(expired)
  );

  // An acknowledge in the expiring cycle still counts as a normal completion.
  assign timeout_hit = in_wait && !bus.MEM_ACK && expired;

  always_ff @(posedge CLK) begin
    if (RES) begin
      err_q <= 1'b0;
    end else if (timeout_hit) begin
      err_q <= 1'b1;
    end
  end

  assign ERR = err_q;
`else
  assign timeout_hit = 1'b0;
  assign ERR         = 1'b0;
`endif

  // Next-state logic; a pending fetch simply waits in IDLE behind a data request.
  always_comb begin
    next_state   = state_q;
    accept_data  = 1'b0;
    accept_instr = 1'b0;
    complete     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.DATA_REQ) begin
          accept_data = 1'b1;
          next_state  = DATA_WAIT;
        end else if (bus.INSTR_REQ) begin
          accept_instr = 1'b1;
          next_state   = INSTR_WAIT;
        end
      end
      INSTR_WAIT, DATA_WAIT: begin
        if (bus.MEM_ACK) begin
          complete   = 1'b1;
          next_state = RECOVER;
        end else if (timeout_hit) begin
          next_state = RECOVER;
        end
      end
      RECOVER: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State and datapath registers. VALID flags are set on the edge that
  // enters RECOVER, so they are high for exactly the RECOVER cycle.
  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q       <= IDLE;
      adr_q         <= '0;
      wdata_q       <= '0;
      we_q          <= 1'b0;
      instr_read_q  <= '0;
      data_read_q   <= '0;
      instr_valid_q <= 1'b0;
      data_valid_q  <= 1'b0;
    end else begin
      state_q       <= next_state;
      instr_valid_q <= 1'b0;
      data_valid_q  <= 1'b0;

      if (accept_data) begin
        adr_q   <= bus.DATA_ADR;
        wdata_q <= bus.DATA_WRITE;
        we_q    <= bus.DATA_WRITE_ENABLE;
      end else if (accept_instr) begin
        adr_q   <= bus.INSTR_ADR;
        wdata_q <= '0;
        we_q    <= 1'b0;
      end

      if (complete) begin
        if (state_q == INSTR_WAIT) begin
          instr_read_q  <= bus.MEM_RDATA;
          instr_valid_q <= 1'b1;
        end else begin
          data_valid_q <= 1'b1;
          if (!we_q) begin
            data_read_q <= bus.MEM_RDATA;
          end
        end
      end else if (timeout_hit) begin
        if (state_q == INSTR_WAIT) begin
          instr_read_q  <= DATA_W'(NOP_INSTR);
          instr_valid_q <= 1'b1;
        end else begin
          data_valid_q <= 1'b1;
          if (!we_q) begin
            data_read_q <= DATA_W'(DATA_TIMEOUT_WORD);
          end
        end
      end
    end
  end

  assign bus.MEM_REQ     = in_wait;
  assign bus.MEM_WE      = in_wait && we_q;
  assign bus.MEM_ADR     = adr_q;
  assign bus.MEM_WDATA   = wdata_q;
  assign bus.INSTR_READ  = instr_read_q;
  assign bus.INSTR_VALID = instr_valid_q;
  assign bus.DATA_READ   = data_read_q;
  assign bus.DATA_VALID  = data_valid_q;
  assign BUSY            = (state_q != IDLE);

endmodule
